// File: rtl/pipe_pkg.sv
// Shared definitions for the EX->WB pipeline stage: state encoding, default widths
// and the writeback entry layout.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_RD_W   = 3;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_FULL  = ST_FULL,
    S_SKID  = ST_SKID
  } skid_state_e;

  typedef struct packed {
    logic                    reg_write;
    logic [DEFAULT_RD_W-1:0] rd;
    logic [DEFAULT_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/stage_skid_buf.sv
// Generic 2-entry skid buffer with valid/ready handshake and synchronous flush.
// in_ready and out_valid decode from state only, so ready never ripples upstream.
module stage_skid_buf
  import pipe_pkg::*;
#(
  parameter int              W          = 8,
  parameter logic [W-1:0]    FLUSH_MASK = '0   // bits cleared in both entries on flush
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         acc;
  logic         dep;

  assign in_ready  = (state != S_SKID);
  assign out_valid = (state != S_EMPTY);
  assign out_data  = main_q;
  assign acc       = in_valid & in_ready;
  assign dep       = out_valid & out_ready;

  // NOTE: both entries are plain registers with an async reset, so the out_* fields
  // read as zero straight after reset rather than as stale data.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= S_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state  <= S_EMPTY;
      main_q <= main_q & ~FLUSH_MASK;
      skid_q <= skid_q & ~FLUSH_MASK;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (acc) begin
            main_q <= in_data;
            state  <= S_FULL;
          end
        end
        S_FULL: begin
          if (acc && dep) begin
            main_q <= in_data;
          end else if (acc) begin
            skid_q <= in_data;
            state  <= S_SKID;
          end else if (dep) begin
            state  <= S_EMPTY;
          end
        end
        S_SKID: begin
          if (dep) begin
            main_q <= skid_q;
            state  <= S_FULL;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/ex_wb_pipe_stage.sv
// EX->WB pipeline stage: skid-buffered {reg_write, rd, data} plus forwarding compare.
// Optional stall counter built when STAGE_PERF_CNT_EN is defined.
module ex_wb_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int RD_W         = DEFAULT_RD_W,
  parameter int R0_HARDWIRED = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_write,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_data,
  input  logic [RD_W-1:0]   src_a,
  input  logic [RD_W-1:0]   src_b,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [DATA_W-1:0] fwd_data
`ifdef STAGE_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int             ENT_W    = 1 + RD_W + DATA_W;
  localparam logic [ENT_W-1:0] RW_MASK = {1'b1, {(ENT_W-1){1'b0}}};
  localparam bit             R0_IS_HW = (R0_HARDWIRED != 0);

  logic [ENT_W-1:0]  in_ent;
  logic [ENT_W-1:0]  head_ent;
  logic              head_rw;
  logic              head_can_fwd;

  assign in_ent = {in_reg_write, in_rd, in_data};

  stage_skid_buf #(
    .W          (ENT_W),
    .FLUSH_MASK (RW_MASK)
  ) u_skid (
    .Clk       (Clk),
    .Reset     (Reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_ent),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_ent)
  );

  assign {head_rw, out_rd, out_data} = head_ent;
  assign out_reg_write = out_valid & head_rw;
  assign fwd_data      = out_data;

  // Only the head is compared; a younger skid entry holds in_ready low, which stalls EX.
  assign head_can_fwd = out_reg_write & ~(R0_IS_HW & (out_rd == '0));
  assign fwd_a_hit    = head_can_fwd & (out_rd == src_a);
  assign fwd_b_hit    = head_can_fwd & (out_rd == src_b);

`ifdef STAGE_PERF_CNT_EN
  // Saturating count of cycles WB refused a valid head; flush leaves it alone.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
